// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, colours and playfield defaults for the pong ball datapath
package pong_pkg;

    typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, HOLD} state_t;

    localparam logic [2:0] COLOR_BLACK = 3'd0;
    localparam int STEP_W = 4;

    localparam int DEF_XW = 8;
    localparam int DEF_YW = 7;
    localparam int DEF_SIZE_LOG2 = 2;
    localparam int DEF_X_MIN = 51;
    localparam int DEF_X_MAX = 108;
    localparam int DEF_Y_TOP = 12;
    localparam int DEF_Y_BOT = 107;
    localparam int DEF_X_START = 80;
    localparam int DEF_Y_START = 60;
    localparam int DEF_PADDLE_W = 16;

    // Pixels per move: one more per completed level of paddle hits, capped at step_max.
    function automatic logic [STEP_W-1:0] step_for(input logic [7:0] hits, input int per_level, input int step_max);
        int lvl;
        lvl = int'(hits) / per_level;
        return STEP_W'(1 + (lvl < step_max - 1 ? lvl : step_max - 1));
    endfunction

endpackage

// File: rtl/pong_ball_kinematics.sv
// pong_ball_kinematics: combinational next-position, wall/paddle reflection and score decision
module pong_ball_kinematics
    import pong_pkg::*;
#(
    parameter int XW = DEF_XW,
    parameter int YW = DEF_YW,
    parameter int SIZE_LOG2 = DEF_SIZE_LOG2,
    parameter int X_MIN = DEF_X_MIN,
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_TOP = DEF_Y_TOP,
    parameter int Y_BOT = DEF_Y_BOT,
    parameter int X_START = DEF_X_START,
    parameter int Y_START = DEF_Y_START,
    parameter int PADDLE_W = DEF_PADDLE_W
) (
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic              dx,
    input  logic              dy,
    input  logic [STEP_W-1:0] step,
    input  logic [XW-1:0]     paddle_x_bot,
    input  logic [XW-1:0]     paddle_x_top,
    output logic [XW-1:0]     nx,
    output logic [YW-1:0]     ny,
    output logic              ndx,
    output logic              ndy,
    output logic              hit,
    output logic              score_top,
    output logic              score_bot
);

    localparam int S = 1 << SIZE_LOG2;

    int sx, sy, cx, cy;

    // Signed 32-bit arithmetic never wraps; x walls first, then the y edge may reflect or respawn.
    always_comb begin
        sx = dx ? int'(x) + int'(step) : int'(x) - int'(step);
        sy = dy ? int'(y) + int'(step) : int'(y) - int'(step);
        ndx = dx;
        ndy = dy;
        hit = 1'b0;
        score_top = 1'b0;
        score_bot = 1'b0;
        cx = sx;
        cy = sy;
        if (sx + S - 1 >= X_MAX) begin
            cx = X_MAX - S + 1;
            ndx = 1'b0;
        end else if (sx <= X_MIN) begin
            cx = X_MIN;
            ndx = 1'b1;
        end
        if (dy && sy + S - 1 >= Y_BOT) begin
            if (cx + S - 1 >= int'(paddle_x_bot) && cx <= int'(paddle_x_bot) + PADDLE_W - 1) begin
                cy = Y_BOT - S + 1;
                ndy = 1'b0;
                hit = 1'b1;
            end else begin
                score_top = 1'b1;
                cx = X_START;
                cy = Y_START;
                ndx = dx;
                ndy = 1'b1;
            end
        end else if (!dy && sy <= Y_TOP) begin
            if (cx + S - 1 >= int'(paddle_x_top) && cx <= int'(paddle_x_top) + PADDLE_W - 1) begin
                cy = Y_TOP;
                ndy = 1'b1;
                hit = 1'b1;
            end else begin
                score_bot = 1'b1;
                cx = X_START;
                cy = Y_START;
                ndx = dx;
                ndy = 1'b0;
            end
        end
        nx = XW'(cx);
        ny = YW'(cy);
    end

endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: per-go erase/move/draw/hold sequencer emitting the ball pixel stream
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int XW = DEF_XW,
    parameter int YW = DEF_YW,
    parameter int SIZE_LOG2 = DEF_SIZE_LOG2,
    parameter int X_MIN = DEF_X_MIN,
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_TOP = DEF_Y_TOP,
    parameter int Y_BOT = DEF_Y_BOT,
    parameter int X_START = DEF_X_START,
    parameter int Y_START = DEF_Y_START,
    parameter int PADDLE_W = DEF_PADDLE_W,
    parameter int HITS_PER_LEVEL = 4,
    parameter int STEP_MAX = 3,
    parameter int HOLD_EASY = 35,
    parameter int HOLD_HARD = 20
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          go,
    input  logic          difficulty,
    input  logic [2:0]    ball_color,
    input  logic [XW-1:0] paddle_x_bot,
    input  logic [XW-1:0] paddle_x_top,
    output logic          plot,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [2:0]    color_out,
    output logic          busy,
    output logic          done,
    output logic          score_top,
    output logic          score_bot,
    output logic [7:0]    rally_hits
);

    localparam int NW = 2 * SIZE_LOG2;
    localparam int N = 1 << NW;
    localparam int HW = $clog2((HOLD_EASY > HOLD_HARD ? HOLD_EASY : HOLD_HARD) + 1);

    state_t state;
    logic [NW-1:0] i, ni;
    logic [HW-1:0] hold_cnt;
    logic [XW-1:0] x, kx;
    logic [YW-1:0] y, ky;
    logic dx, dy, kdx, kdy, khit, kst, ksb;
    logic [STEP_W-1:0] step;

    assign ni = i + 1'b1;
    assign step = step_for(rally_hits, HITS_PER_LEVEL, STEP_MAX);
    assign score_top = (state == MOVE) && kst;
    assign score_bot = (state == MOVE) && ksb;

    pong_ball_kinematics #(
        .XW(XW), .YW(YW), .SIZE_LOG2(SIZE_LOG2), .X_MIN(X_MIN), .X_MAX(X_MAX),
        .Y_TOP(Y_TOP), .Y_BOT(Y_BOT), .X_START(X_START), .Y_START(Y_START), .PADDLE_W(PADDLE_W)
    ) kin (
        .x(x), .y(y), .dx(dx), .dy(dy), .step(step),
        .paddle_x_bot(paddle_x_bot), .paddle_x_top(paddle_x_top),
        .nx(kx), .ny(ky), .ndx(kdx), .ndy(kdy), .hit(khit), .score_top(kst), .score_bot(ksb)
    );

    // Sequencer: pixel outputs are registered one pixel ahead so the first plot follows go by one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            i <= '0;
            hold_cnt <= '0;
            x <= XW'(X_START);
            y <= YW'(Y_START);
            dx <= 1'b1;
            dy <= 1'b1;
            rally_hits <= '0;
            plot <= 1'b0;
            x_out <= '0;
            y_out <= '0;
            color_out <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state <= ERASE;
                    busy <= 1'b1;
                    plot <= 1'b1;
                    i <= '0;
                    x_out <= x;
                    y_out <= y;
                    color_out <= COLOR_BLACK;
                end
                ERASE: if (i == NW'(N - 1)) begin
                    state <= MOVE;
                    plot <= 1'b0;
                end else begin
                    i <= ni;
                    x_out <= x + XW'(ni[SIZE_LOG2-1:0]);
                    y_out <= y + YW'(ni[NW-1:SIZE_LOG2]);
                end
                MOVE: begin
                    state <= DRAW;
                    x <= kx;
                    y <= ky;
                    dx <= kdx;
                    dy <= kdy;
                    rally_hits <= (kst || ksb) ? 8'd0 : (khit && rally_hits != 8'hFF) ? rally_hits + 8'd1 : rally_hits;
                    plot <= 1'b1;
                    i <= '0;
                    x_out <= kx;
                    y_out <= ky;
                    color_out <= ball_color;
                end
                DRAW: if (i == NW'(N - 1)) begin
                    state <= HOLD;
                    plot <= 1'b0;
                    hold_cnt <= difficulty ? HW'(HOLD_HARD - 1) : HW'(HOLD_EASY - 1);
                end else begin
                    i <= ni;
                    x_out <= x + XW'(ni[SIZE_LOG2-1:0]);
                    y_out <= y + YW'(ni[NW-1:SIZE_LOG2]);
                    color_out <= ball_color;
                end
                HOLD: if (hold_cnt == '0) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: directed frame-by-frame checks of the pong ball engine
module tb_pong_ball_engine;

    logic clk = 1'b0;
    logic resetn, go, difficulty;
    logic [2:0] ball_color, color_out;
    logic [7:0] paddle_x_bot, paddle_x_top, x_out, rally_hits;
    logic [6:0] y_out;
    logic plot, busy, done, score_top, score_bot;

    int errors = 0;
    int checks = 0;
    int xb, yb, xa, ya, nst, nsb;

    pong_ball_engine dut (
        .clk(clk), .resetn(resetn), .go(go), .difficulty(difficulty), .ball_color(ball_color),
        .paddle_x_bot(paddle_x_bot), .paddle_x_top(paddle_x_top), .plot(plot), .x_out(x_out),
        .y_out(y_out), .color_out(color_out), .busy(busy), .done(done), .score_top(score_top),
        .score_bot(score_bot), .rally_hits(rally_hits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One go-to-done update; records first erase/draw pixel and score pulses, optionally checks every pixel.
    task automatic frame(input bit chk, input int go_at, input int hold, input int ex0, input int ey0, input int ex1, input int ey1);
        int cyc, pix, k;
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        cyc = 0;
        pix = 0;
        nst = 0;
        nsb = 0;
        check("first_plot", int'(plot), 1);
        while (busy && cyc < 300) begin
            if (chk) check("plot_pattern", int'(plot), int'(cyc < 16 || (cyc >= 17 && cyc < 33)));
            if (plot) begin
                if (pix == 0) begin xb = int'(x_out); yb = int'(y_out); end
                if (pix == 16) begin xa = int'(x_out); ya = int'(y_out); end
                if (chk) begin
                    k = pix % 16;
                    check("pix_x", int'(x_out), (pix < 16 ? ex0 : ex1) + k % 4);
                    check("pix_y", int'(y_out), (pix < 16 ? ey0 : ey1) + k / 4);
                    check("pix_color", int'(color_out), pix < 16 ? 0 : int'(ball_color));
                end
                pix++;
            end
            nst += int'(score_top);
            nsb += int'(score_bot);
            go = (cyc == go_at);
            cyc++;
            @(negedge clk);
        end
        go = 1'b0;
        check("busy_cycles", cyc, 33 + hold);
        check("pixel_count", pix, 32);
        check("done", int'(done), 1);
        @(negedge clk) check("done_pulse", int'(done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits, total, st, yprev, xprev, busy_seen;
        bit up, got;
        resetn = 1'b0;
        go = 1'b0;
        difficulty = 1'b1;
        ball_color = 3'd5;
        paddle_x_bot = 8'd80;
        paddle_x_top = 8'd20;
        repeat (3) @(negedge clk);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_scores", int'(score_top) + int'(score_bot), 0);
        check("rst_rally", int'(rally_hits), 0);
        check("rst_xy", int'(x_out) + int'(y_out) + int'(color_out), 0);
        resetn = 1'b1;

        frame(1, -1, 20, 80, 60, 81, 61);
        difficulty = 1'b0;
        frame(1, -1, 35, 81, 61, 82, 62);
        difficulty = 1'b1;
        frame(0, 20, 20, 0, 0, 0, 0);
        check("gd_xb", xb, 82);
        check("gd_xa", xa, 83);
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            busy_seen += int'(busy);
        end
        check("no_extra_frame", busy_seen, 0);

        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_erase_plot", int'(plot), 1);
        #2 resetn = 1'b0;
        #1;
        check("arst_plot", int'(plot), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_x", int'(x_out), 0);
        @(negedge clk) resetn = 1'b1;
        frame(0, -1, 20, 0, 0, 0, 0);
        check("after_rst_xb", xb, 80);
        check("after_rst_yb", yb, 60);
        check("after_rst_xa", xa, 81);
        check("after_rst_ya", ya, 61);

        for (int n = 2; n <= 136; n++) begin
            frame(0, -1, 20, 0, 0, 0, 0);
            if (n == 25) begin check("wall_r_x", xa, 105); check("wall_r_y", ya, 85); end
            if (n == 26) check("wall_r_back", xa, 104);
            if (n == 44) begin
                check("bot_hit_x", xa, 86);
                check("bot_hit_y", ya, 104);
                check("bot_hit_rally", int'(rally_hits), 1);
                check("bot_hit_noscore", nst + nsb, 0);
            end
            if (n == 79) check("wall_l_x", xa, 51);
            if (n == 136) begin
                check("top_miss_sb", nsb, 1);
                check("top_miss_st", nst, 0);
                check("top_miss_x", xa, 80);
                check("top_miss_y", ya, 60);
                check("top_miss_rally", int'(rally_hits), 0);
            end
        end

        hits = 0;
        total = 0;
        up = 1'b1;
        yprev = 60;
        xprev = 80;
        for (int f = 0; f < 1500 && hits < 13; f++) begin
            paddle_x_top = 8'(xprev - 6);
            paddle_x_bot = 8'(xprev - 6);
            st = 1 + (hits / 4 < 2 ? hits / 4 : 2);
            frame(0, -1, 20, 0, 0, 0, 0);
            total += nst + nsb;
            if (up && ya == 12) begin
                hits++;
                up = 1'b0;
                check("rally_top", int'(rally_hits), hits);
            end else if (!up && ya == 104) begin
                hits++;
                up = 1'b1;
                check("rally_bot", int'(rally_hits), hits);
            end else begin
                check("step", up ? yprev - ya : ya - yprev, st);
            end
            yprev = ya;
            xprev = xa;
        end
        check("hits_reached", hits, 13);
        check("rally_noscore", total, 0);

        paddle_x_bot = 8'd0;
        got = 1'b0;
        for (int f = 0; f < 200 && !got; f++) begin
            paddle_x_top = 8'(xprev - 6);
            frame(0, -1, 20, 0, 0, 0, 0);
            xprev = xa;
            if (nst > 0) begin
                got = 1'b1;
                check("bot_miss_st", nst, 1);
                check("bot_miss_sb", nsb, 0);
                check("bot_miss_x", xa, 80);
                check("bot_miss_y", ya, 60);
                check("bot_miss_rally", int'(rally_hits), 0);
            end
        end
        check("bot_miss_seen", int'(got), 1);
        frame(0, -1, 20, 0, 0, 0, 0);
        check("serve_down_y", ya, 61);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
